// File: rtl/mcu0_mem_arbiter.sv
// mcu0_mem_arbiter: round-robin arbiter that gives two 16-bit word ports access to the
// byte-wide synchronous MCU0 memory, one big-endian word (two byte cycles) at a time.
module mcu0_mem_arbiter #(
    parameter int AW = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [15:0]   wdata0,
    output logic          gnt0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [15:0]   wdata1,
    output logic          gnt1,
    output logic          ack1,
    output logic [15:0]   rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [1:0]    dbg_state
);

    // Requester handshake: hold reqN/weN/addrN/wdataN stable until gntN pulses; the
    // arbiter samples them only on an IDLE edge. ackN pulses one cycle when the word is
    // done, and rdata is valid in that cycle for reads. A req still high during ack
    // requests another word.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic          r_sel;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_wdata;
    logic [7:0]    r_hi;
    logic [15:0]   r_rdata;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_ack0;
    logic          r_ack1;

    logic          w_win;
    logic          w_sel;
    logic [AW-1:0] w_addr_lo;

    assign w_win     = req0 | req1;
    assign w_sel     = (req0 & req1) ? ~r_last : req1;
    assign w_addr_lo = r_addr + AW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_win ? HI : IDLE;
            HI:      w_next = LO;
            LO:      w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        case (r_state)
            HI: begin
                mem_addr  = r_addr;
                mem_we    = r_we;
                mem_wdata = r_wdata[15:8];
            end
            LO: begin
                mem_addr  = w_addr_lo;
                mem_we    = r_we;
                mem_wdata = r_wdata[7:0];
            end
            FIN: begin
                mem_addr  = w_addr_lo;
            end
            default: ;
        endcase
    end

    // Memory read data lags the address by one cycle: the high byte is on mem_rdata
    // during LO, the low byte during FIN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 16'h0000;
            r_hi    <= 8'h00;
            r_rdata <= 16'h0000;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win) begin
                        r_sel   <= w_sel;
                        r_last  <= w_sel;
                        r_we    <= w_sel ? we1 : we0;
                        r_addr  <= w_sel ? addr1 : addr0;
                        r_wdata <= w_sel ? wdata1 : wdata0;
                        r_gnt0  <= ~w_sel;
                        r_gnt1  <= w_sel;
                    end
                end
                LO: begin
                    r_hi <= mem_rdata;
                end
                FIN: begin
                    if (!r_we) begin
                        r_rdata <= {r_hi, mem_rdata};
                    end
                    r_ack0 <= ~r_sel;
                    r_ack1 <= r_sel;
                end
                default: ;
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mcu0_mem_arbiter.sv
// tb_mcu0_mem_arbiter: bench for mcu0_mem_arbiter with a byte-wide synchronous memory
// model, per-port drivers and an ack-ordered scoreboard of {port, rdata}.
module tb_mcu0_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, ack0, gnt1, ack1, busy, mem_we;
    logic [15:0] rdata;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [1:0]  dbg_state;

    logic [7:0]  mem [0:4095] = '{default: 8'h00};
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int ack_cnt = 0;
    int g_cyc[2] = '{0, 0};
    logic [16:0] exp_q[$];
    int gnt_log[$];
    int gcyc_log[$];
    logic [15:0] last_rd = 16'h0000;

    mcu0_mem_arbiter #(.AW(12)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clock) begin
        logic [16:0] e;
        int p;
        if (!reset) begin
            if (mem_we) we_cnt++;
            if (gnt0 || gnt1) begin
                check("gnt_excl", int'(gnt0 && gnt1), 0);
                p = int'(gnt1);
                g_cyc[p] = cyc;
                gnt_log.push_back(p);
                gcyc_log.push_back(cyc);
            end
            if (ack0 || ack1) begin
                check("ack_excl", int'(ack0 && ack1), 0);
                p = int'(ack1);
                check("ack_lat", cyc - g_cyc[p], 3);
                if (exp_q.size() == 0) begin
                    check("ack_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", p, int'(e[16]));
                    check("rdata", int'(rdata), int'(e[15:0]));
                end
                ack_cnt++;
            end
        end
    end

    // driver tasks
    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic push_exp(input logic p, input logic we, input logic [15:0] d);
        if (we) begin
            exp_q.push_back({p, last_rd});
        end else begin
            exp_q.push_back({p, d});
            last_rd = d;
        end
    endtask

    task automatic set_port(input int port, input logic we, input logic [11:0] a,
                            input logic [15:0] wd);
        if (port == 0) begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        else begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
    endtask

    task automatic issue(input int port, input logic we, input logic [11:0] a,
                         input logic [15:0] wd, output int ng, output int na);
        ng = 0;
        na = 0;
        set_port(port, we, a, wd);
        do begin
            @(negedge clock); ng++;
        end while (!(port == 0 ? gnt0 : gnt1) && ng < 30);
        if (ng >= 30) check("gnt_timeout", 1, 0);
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        do begin
            @(negedge clock); na++;
        end while (!(port == 0 ? ack0 : ack1) && na < 30);
        if (na >= 30) check("ack_timeout", 1, 0);
        #1;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clock); #1; n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, na, n, base_g, base_a, w0, ng2, na2;

        poke(12'h010, 8'h12);
        poke(12'h011, 8'h34);
        #1;
        check("rst_gnt0", int'(gnt0), 0);
        check("rst_gnt1", int'(gnt1), 0);
        check("rst_ack", int'(ack0 | ack1), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_state", int'(dbg_state), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;

        // port 0 read of preloaded word
        push_exp(1'b0, 1'b0, 16'h1234);
        issue(0, 1'b0, 12'h010, 16'h0000, ng, na);
        check("rd_gnt_lat", ng, 1);
        check("rd_ack_lat", na, 3);
        check("rd_port0_only", gnt_log[gnt_log.size()-1], 0);

        // port 1 write then port 0 readback
        w0 = we_cnt;
        push_exp(1'b1, 1'b1, 16'hBEEF);
        issue(1, 1'b1, 12'h020, 16'hBEEF, ng, na);
        check("wr_we_cycles", we_cnt - w0, 2);
        check("wr_mem_hi", int'(mem[12'h020]), 8'hBE);
        check("wr_mem_lo", int'(mem[12'h021]), 8'hEF);
        push_exp(1'b0, 1'b0, 16'hBEEF);
        issue(0, 1'b0, 12'h020, 16'h0000, ng, na);

        // leaves last=1 so the following tie starts at port 0
        push_exp(1'b1, 1'b0, 16'h1234);
        issue(1, 1'b0, 12'h010, 16'h0000, ng, na);

        // both ports held: round-robin 0,1,0,1
        base_g = gnt_log.size();
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 1'b0, 16'h1234);
            push_exp(1'b1, 1'b0, 16'hBEEF);
        end
        set_port(0, 1'b0, 12'h010, 16'h0000);
        set_port(1, 1'b0, 12'h020, 16'h0000);
        n = 0;
        while (gnt_log.size() < base_g + 4 && n < 40) begin
            @(negedge clock); #1; n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_grants", gnt_log.size() - base_g, 4);
        drain(20);
        if (gnt_log.size() >= base_g + 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", gnt_log[base_g+i], i % 2);
            for (int i = 1; i < 4; i++)
                check("rr_spacing", gcyc_log[base_g+i] - gcyc_log[base_g+i-1], 4);
        end

        // write wrapping the top of memory, then read it back
        push_exp(1'b0, 1'b1, 16'hA55A);
        issue(0, 1'b1, 12'hFFF, 16'hA55A, ng, na);
        check("wrap_mem_hi", int'(mem[12'hFFF]), 8'hA5);
        check("wrap_mem_lo", int'(mem[12'h000]), 8'h5A);
        push_exp(1'b0, 1'b0, 16'hA55A);
        issue(0, 1'b0, 12'hFFF, 16'h0000, ng, na);

        // reset during the LO cycle of a write
        set_port(0, 1'b1, 12'h030, 16'h1111);
        n = 0;
        do begin
            @(negedge clock); n++;
        end while (!gnt0 && n < 30);
        req0 = 1'b0;
        @(negedge clock);
        check("abort_in_lo", int'(dbg_state), 2);
        reset = 1'b1;
        #1;
        check("abort_rdata", int'(rdata), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_mem_we", int'(mem_we), 0);
        check("abort_mem_addr", int'(mem_addr), 0);
        check("abort_ack", int'(ack0 | ack1 | gnt0 | gnt1), 0);
        last_rd = 16'h0000;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        check("abort_mem_hi", int'(mem[12'h030]), 8'h11);
        check("abort_mem_lo", int'(mem[12'h031]), 8'h00);

        // post-reset tie goes to port 0
        base_g = gnt_log.size();
        push_exp(1'b0, 1'b0, 16'h1100);
        push_exp(1'b1, 1'b0, 16'hA55A);
        fork
            issue(0, 1'b0, 12'h030, 16'h0000, ng, na);
            issue(1, 1'b0, 12'hFFF, 16'h0000, ng2, na2);
        join
        drain(20);
        check("tie_after_rst", gnt_log.size() >= base_g + 2 ? gnt_log[base_g] : -1, 0);

        // port 0 held alone: back-to-back words
        base_g = gnt_log.size();
        base_a = ack_cnt;
        for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 16'hBEEF);
        set_port(0, 1'b0, 12'h020, 16'h0000);
        n = 0;
        while (ack_cnt - base_a < 3 && n < 40) begin
            @(negedge clock); #1; n++;
            if (gnt_log.size() - base_g >= 3) req0 = 1'b0;
            if (gnt_log.size() > base_g)
                check("b2b_busy", int'(busy), int'(!(ack0 || ack1)));
        end
        req0 = 1'b0;
        check("b2b_acks", ack_cnt - base_a, 3);
        if (gnt_log.size() >= base_g + 3)
            for (int i = 1; i < 3; i++)
                check("b2b_spacing", gcyc_log[base_g+i] - gcyc_log[base_g+i-1], 4);
        drain(10);
        repeat (6) @(negedge clock);
        check("no_extra_gnt", gnt_log.size() - base_g, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
